// File: rtl/hazard_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : hazard_unit                                                    |
// | Brief   : Pipeline hazard detection, stall/flush control, operand        |
// |           forwarding select and saturating performance counters.         |
// | Config  : HAZARD_FORWARDING_EN - defined: EX/MEM forwarding with a       |
// |           1-cycle load-use stall; undefined: no forwarding, EX producer   |
// |           stalls 2 cycles, MEM producer stalls 1 cycle.                  |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module hazard_unit #(
  // Internal counter width; outputs are always 32 bits (zero-extended).
  parameter int CNT_W = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  ex_rd,
  input  logic [4:0]  mem_rd,
  input  logic        ex_reg_write,
  input  logic        mem_reg_write,
  input  logic        ex_is_load,
  input  logic        ex_branch_taken,
  output logic        stall,
  output logic        takebranch,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [1:0]       stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, flush_count_q;

  logic       ex_match_a, ex_match_b, mem_match_a, mem_match_b;
  logic       ex_match;
  logic [1:0] hazard_n;   // stall length demanded by the current ID instruction

  // A producer only matters when it really writes a nonzero register the
  // consumer really reads; x0 is never a dependency.
  assign ex_match_a  = id_uses_rs1 && ex_reg_write  && (ex_rd  != 5'd0) && (ex_rd  == id_rs1);
  assign ex_match_b  = id_uses_rs2 && ex_reg_write  && (ex_rd  != 5'd0) && (ex_rd  == id_rs2);
  assign mem_match_a = id_uses_rs1 && mem_reg_write && (mem_rd != 5'd0) && (mem_rd == id_rs1);
  assign mem_match_b = id_uses_rs2 && mem_reg_write && (mem_rd != 5'd0) && (mem_rd == id_rs2);
  assign ex_match    = ex_match_a || ex_match_b;

`ifdef HAZARD_FORWARDING_EN
  // Only a load result is too late to forward from EX; everything else bypasses.
  assign hazard_n = (ex_is_load && ex_match) ? 2'd1 : 2'd0;
  // EX result is younger than MEM result, so it wins when both match.
  assign fwd_a    = ex_match_a ? 2'b01 : (mem_match_a ? 2'b10 : 2'b00);
  assign fwd_b    = ex_match_b ? 2'b01 : (mem_match_b ? 2'b10 : 2'b00);
`else
  logic mem_match;
  logic unused_load;
  assign mem_match   = mem_match_a || mem_match_b;
  assign unused_load = ex_is_load;
  // Without bypassing, wait until the producer has reached WB (write-before-read).
  assign hazard_n    = ex_match ? 2'd2 : (mem_match ? 2'd1 : 2'd0);
  assign fwd_a       = 2'b00;
  assign fwd_b       = 2'b00;
`endif

  assign takebranch   = ex_branch_taken;
  assign stall_cycles = 32'(stall_cycles_q);
  assign flush_count  = 32'(flush_count_q);

  // State and remaining-hold-count registers; reset abandons any stall at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      stall_cnt_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next-state and stall decode; a taken branch squashes any hazard in progress.
  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    stall       = 1'b0;
    if (ex_branch_taken) begin
      state_d     = RUN;
      stall_cnt_d = 2'd0;
    end else if (state_q == HOLD) begin
      stall       = 1'b1;
      stall_cnt_d = stall_cnt_q - 2'd1;
      if (stall_cnt_q == 2'd1) begin
        state_d = RUN;
      end
    end else begin
      stall = (hazard_n != 2'd0);
      if (hazard_n > 2'd1) begin
        state_d     = HOLD;
        stall_cnt_d = hazard_n - 2'd1;
      end else begin
        stall_cnt_d = 2'd0;
      end
    end
    if (reset) begin
      stall = 1'b0;
    end
  end

  // Saturating performance counters for stall and flush cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (stall && (stall_cycles_q != CNT_MAX)) begin
        stall_cycles_q <= stall_cycles_q + CNT_ONE;
      end
      if (takebranch && (flush_count_q != CNT_MAX)) begin
        flush_count_q <= flush_count_q + CNT_ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 The module SHALL use one clock and an asynchronous, active-high reset; ports are named clock and reset.
REQ-002 clock  input  1  rising-edge clock shared with the pipeline registers.
REQ-003 reset  input  1  asynchronous, active-high; clears all state.
REQ-004 id_rs1, id_rs2  input  5 each  source registers of the instruction in ID.
REQ-005 id_uses_rs1, id_uses_rs2  input  1 each  the ID instruction reads that source.
REQ-006 ex_rd, mem_rd  input  5 each  destination registers of the instructions in EX and MEM.
REQ-007 ex_reg_write, mem_reg_write  input  1 each  the instruction in EX or MEM writes rd.
REQ-008 ex_is_load  input  1  the EX instruction is a load.
REQ-009 ex_branch_taken  input  1  the EX instruction resolved taken (branch or jump).
REQ-010 stall  output  1  freezes IF/ID and injects a NOP into ID/EX this cycle.
REQ-011 takebranch  output  1  squashes IF/ID this cycle.
REQ-012 fwd_a, fwd_b  output  2 each  operand source for EX: 00 register file, 01 EX/MEM result, 10 MEM/WB result.
REQ-013 stall_cycles, flush_count  output  32 each  performance counters.

Function
REQ-014 A source matches a producer only if its use flag is set, the producer's reg_write is set, its rd is nonzero and rd equals the source.
REQ-015 takebranch SHALL equal ex_branch_taken combinationally, with zero latency.
REQ-016 When ex_branch_taken=1, stall SHALL be 0, the stall counter SHALL clear at the next edge, and the cycle SHALL NOT count as a stall cycle.
- Branch overrides any hazard, including one in progress.
REQ-017 The block has two states, RUN and HOLD, plus a 2-bit counter stall_cnt.
- In HOLD, stall=1 regardless of the ID/EX inputs.
- stall_cnt decrements each edge; HOLD returns to RUN when stall_cnt is 1.
REQ-018 In RUN, stall SHALL be combinational from the hazard rule (Configuration).
- For an N-cycle hazard with N>1, the next state is HOLD with stall_cnt=N-1.
- For N=1, the state stays RUN.
REQ-019 The register file is write-before-read: a producer in WB never causes a hazard.
REQ-020 stall_cycles SHALL increment on every edge where stall=1.
REQ-021 flush_count SHALL increment on every edge where takebranch=1.
REQ-022 Both counters SHALL saturate at 32'hFFFFFFFF and never wrap.
REQ-023 fwd_a and fwd_b SHALL be combinational; when both EX and MEM match, EX SHALL take priority.

Reset
REQ-024 While reset is asserted:
- state=RUN, stall_cnt=0, stall_cycles=0, flush_count=0;
- stall=0 and takebranch follows ex_branch_taken.
REQ-025 Reset asserted mid-HOLD SHALL abandon the stall immediately, without waiting for a clock edge.

Configuration
REQ-026 Macro HAZARD_FORWARDING_EN selects the hazard rule.
REQ-027 With HAZARD_FORWARDING_EN defined, the hazard rule is:
- a load-use hazard stalls for N=1 cycle: ex_is_load=1 and an EX match on either source;
- fwd_a and fwd_b follow REQ-012 and REQ-023;
- a non-load EX match is forwarded with 01 and does not stall.
REQ-028 With HAZARD_FORWARDING_EN undefined, the hazard rule is:
- an EX match gives N=2;
- a MEM match alone gives N=1;
- fwd_a and fwd_b are tied to 00.

Verification
REQ-029 FORWARDING_EN on: lw x5 in EX with x5 used as rs1 in ID -> stall=1 for exactly 1 cycle; next cycle fwd_a=10; stall_cycles=1.
REQ-030 FORWARDING_EN on: add x5 in EX and add x5 in MEM, with rs2=x5 -> fwd_b=01, stall=0.
REQ-031 FORWARDING_EN off: add x7 in EX with rs1=x7 -> stall high for 2 consecutive cycles, then 0; stall_cycles=2.
REQ-032 ex_branch_taken=1 in the same cycle as a load-use match -> stall=0, takebranch=1, flush_count+1, stall_cycles unchanged.
REQ-033 Reset asserted during the second HOLD cycle -> stall drops to 0 asynchronously and both counters read 0.
REQ-034 Counters preloaded near max: 3 further stall cycles from FFFFFFFE -> stall_cycles reads FFFFFFFF.
- rd=x0 as producer with rs1=x0 -> no stall, fwd_a=00.
